// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared state type, tone table and priority helper for the sound sequencer
package sound_pkg;

   typedef enum logic [1:0] {IDLE, SEG0, SEG1, GAP} state_t;

   localparam int SIM_SHIFT = 10;

   // Half periods in 50 MHz clk cycles, [event][segment]: water, traffic, hop, win
   localparam logic [16:0] HALF_PERIOD [4][2] = '{
      '{17'd40337, 17'd45278},
      '{17'd63776, 17'd85131},
      '{17'd28409, 17'd25310},
      '{17'd37921, 17'd28409}
   };

   // Returns {found, index} of the lowest set bit
   function automatic logic [2:0] lowest_set(input logic [3:0] v);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/square_tone_gen.sv
// rtl/square_tone_gen.sv - half-period counter and toggle flop driving the registered speaker bit
module square_tone_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        restart,
   input  logic        mute,
   input  logic [16:0] half_period,
   output logic        tone
);

   logic [16:0] cnt_q, cnt_d;
   logic        toggle_q, toggle_d;
   logic        tone_q;

   // half_period is the value for the coming cycle, so restart lands with the new pitch
   always_comb begin
      cnt_d    = cnt_q + 17'd1;
      toggle_d = toggle_q;
      if (half_period == 17'd0) begin
         cnt_d    = '0;
         toggle_d = 1'b0;
      end else if (restart) begin
         cnt_d    = '0;
         toggle_d = 1'b1;
      end else if (cnt_q == half_period - 17'd1) begin
         cnt_d    = '0;
         toggle_d = ~toggle_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         toggle_q <= 1'b0;
         tone_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         toggle_q <= toggle_d;
         tone_q   <= toggle_d & ~mute;
      end
   end

   assign tone = tone_q;

endmodule

// File: rtl/sound_event_sequencer.sv
// rtl/sound_event_sequencer.sv - latches trigger edges and plays the highest-priority effect on the speaker
module sound_event_sequencer
   import sound_pkg::*;
#(
   parameter int NUM_EVENTS = 4,
   parameter int SEG_CYCLES = 3125000,
   parameter int GAP_CYCLES = 625000,
   parameter int SIM_FAST   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] event_trig,
   input  logic                  mute,
   output logic                  audio_out,
   output logic                  busy,
   output logic [1:0]            active_id
);

   localparam int          HP_SHIFT = (SIM_FAST != 0) ? SIM_SHIFT : 0;
   localparam logic [21:0] SEG_LAST = 22'(SEG_CYCLES - 1);
   localparam logic [19:0] GAP_LAST = 20'(GAP_CYCLES - 1);

   state_t                state_q, state_d;
   logic [1:0]            active_id_q, id_d;
   logic [21:0]           seg_cnt_q, seg_cnt_d;
   logic [19:0]           gap_cnt_q, gap_cnt_d;
   logic [NUM_EVENTS-1:0] pending_q, pending_d, trig_prev_q, rise;
   logic                  busy_q;
   logic [3:0]            mask, clr4;
   logic [2:0]            sel;
   logic                  restart;
   logic [16:0]           half_period;

   always_comb begin
      rise      = event_trig & ~trig_prev_q;
      mask      = (state_q == IDLE) ? 4'hF : ((4'd1 << active_id_q) - 4'd1);
      sel       = lowest_set(4'(pending_q) & mask);
      state_d   = state_q;
      id_d      = active_id_q;
      seg_cnt_d = seg_cnt_q;
      gap_cnt_d = gap_cnt_q;
      clr4      = 4'b0000;
      restart   = 1'b0;
      // Dispatch from IDLE and strict-priority preemption share one path
      if (sel[2]) begin
         state_d   = SEG0;
         id_d      = sel[1:0];
         seg_cnt_d = '0;
         gap_cnt_d = '0;
         clr4      = 4'b0001 << sel[1:0];
         restart   = 1'b1;
      end else begin
         case (state_q)
            SEG0: begin
               if (seg_cnt_q == SEG_LAST) begin
                  state_d   = SEG1;
                  seg_cnt_d = '0;
                  restart   = 1'b1;
               end else begin
                  seg_cnt_d = seg_cnt_q + 22'd1;
               end
            end
            SEG1: begin
               if (seg_cnt_q == SEG_LAST) begin
                  state_d   = GAP;
                  seg_cnt_d = '0;
                  gap_cnt_d = '0;
               end else begin
                  seg_cnt_d = seg_cnt_q + 22'd1;
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = IDLE;
                  id_d    = 2'd0;
               end else begin
                  gap_cnt_d = gap_cnt_q + 20'd1;
               end
            end
            default: ;
         endcase
      end
      // A fresh edge on the index being cleared keeps it pending
      pending_d = (pending_q & ~clr4[NUM_EVENTS-1:0]) | rise;
      case (state_d)
         SEG0:    half_period = HALF_PERIOD[id_d][0] >> HP_SHIFT;
         SEG1:    half_period = HALF_PERIOD[id_d][1] >> HP_SHIFT;
         default: half_period = 17'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         active_id_q <= 2'd0;
         seg_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         pending_q   <= '0;
         // Tracking the live level means a trigger held across reset is not an edge
         trig_prev_q <= event_trig;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_id_q <= id_d;
         seg_cnt_q   <= seg_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pending_q   <= pending_d;
         trig_prev_q <= event_trig;
         busy_q      <= (state_d != IDLE);
      end
   end

   square_tone_gen u_tone (
      .clk         (clk),
      .reset       (reset),
      .restart     (restart),
      .mute        (mute),
      .half_period (half_period),
      .tone        (audio_out)
   );

   assign busy      = busy_q;
   assign active_id = active_id_q;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// tb/tb_sound_event_sequencer.sv - scoreboard bench for the sound event sequencer
module tb_sound_event_sequencer;

   typedef struct packed {
      logic       audio;
      logic       busy;
      logic [1:0] id;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mute = 1'b0;
   logic [3:0] event_trig = 4'b0000;
   logic       audio_out;
   logic       busy;
   logic [1:0] active_id;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   hp_tab [4][2] = '{'{39, 44}, '{62, 83}, '{27, 24}, '{37, 27}};

   always #5 clk = ~clk;

   sound_event_sequencer #(
      .NUM_EVENTS (4),
      .SEG_CYCLES (100),
      .GAP_CYCLES (20),
      .SIM_FAST   (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .event_trig (event_trig),
      .mute       (mute),
      .audio_out  (audio_out),
      .busy       (busy),
      .active_id  (active_id)
   );

   task automatic push_idle(input int n);
      exp_t e;
      e = '0;
      repeat (n) exp_q.push_back(e);
   endtask

   // First len cycles of an effect: 100 cycles per segment, then a 20-cycle gap
   task automatic push_effect(input int id, input bit muted, input int len);
      exp_t e;
      for (int t = 0; t < len; t++) begin
         e.busy = 1'b1;
         e.id   = 2'(id);
         if (t < 100)      e.audio = ((t / hp_tab[id][0]) % 2) == 0;
         else if (t < 200) e.audio = (((t - 100) / hp_tab[id][1]) % 2) == 0;
         else              e.audio = 1'b0;
         if (muted) e.audio = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      reset = 1'b1;
      event_trig = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if ({audio_out, busy, active_id} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_hold cyc=%0d got audio=%b busy=%b id=%0d want 0/0/0", i, audio_out, busy, active_id);
         end
      end
      reset = 1'b0;
      push_idle(10);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL reset_release n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
      end
      compared++;
      if (dut.pending_q !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_pending got %b want 0000", dut.pending_q);
      end
      event_trig = 4'h0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single();
      exp_t e;
      @(negedge clk);
      event_trig[0] = 1'b1;
      push_idle(1);
      push_effect(0, 1'b0, 220);
      push_idle(3);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL single n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
         if (n == 5) event_trig[0] = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      @(negedge clk);
      event_trig = 4'b1010;
      push_idle(1);
      push_effect(1, 1'b0, 220);
      push_idle(1);
      push_effect(3, 1'b0, 220);
      push_idle(3);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL simultaneous n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
         if (n == 5) event_trig = 4'b0000;
      end
   endtask

   task automatic test_preempt();
      exp_t e;
      @(negedge clk);
      event_trig[2] = 1'b1;
      push_idle(1);
      push_effect(2, 1'b0, 50);
      push_effect(0, 1'b0, 220);
      push_idle(3);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL preempt n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
         if (n == 5)  event_trig[2] = 1'b0;
         if (n == 49) event_trig[0] = 1'b1;
         if (n == 60) event_trig[0] = 1'b0;
      end
   endtask

   task automatic test_retrigger();
      exp_t e;
      @(negedge clk);
      event_trig[1] = 1'b1;
      push_idle(1);
      push_effect(1, 1'b0, 220);
      push_idle(1);
      push_effect(1, 1'b0, 220);
      push_idle(1);
      push_effect(3, 1'b0, 220);
      push_idle(3);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL retrigger n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
         if (n == 5)   event_trig[1] = 1'b0;
         if (n == 150) event_trig = 4'b1010;
         if (n == 160) event_trig = 4'b0000;
      end
   endtask

   task automatic test_mute();
      exp_t e;
      @(negedge clk);
      mute = 1'b1;
      event_trig[0] = 1'b1;
      push_idle(1);
      push_effect(0, 1'b1, 220);
      push_idle(3);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL mute n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
         if (n == 5) event_trig[0] = 1'b0;
      end
      mute = 1'b0;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      event_trig[0] = 1'b1;
      push_idle(1);
      push_effect(0, 1'b0, 150);
      push_idle(12);
      for (int n = 0; exp_q.size() > 0; n++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         compared++;
         if ({audio_out, busy, active_id} !== e) begin
            mismatched++;
            $display("FAIL reset_mid n=%0d got audio=%b busy=%b id=%0d want audio=%b busy=%b id=%0d",
                     n, audio_out, busy, active_id, e.audio, e.busy, e.id);
         end
         if (n == 5)   event_trig[0] = 1'b0;
         if (n == 150) reset = 1'b1;
         if (n == 153) reset = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_preempt();
      test_retrigger();
      test_mute();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
